// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register-file write controller
package regfile_pkg;

  localparam int RF_RWIDTH = 6;
  localparam int RF_DWIDTH = 32;
  localparam int RF_DEPTH  = 2 ** RF_RWIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } wr_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin arbiter with a single priority pointer
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic r_rr_ptr;

  // grant the sole requester, or the pointed-to one when both ask
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = r_rr_ptr ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // after a grant, favour the requester that did not get it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (gnt[0]) begin
      r_rr_ptr <= 1'b1;
    end else if (gnt[1]) begin
      r_rr_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// rtl/regfile_wr_ctrl.sv - register-file write port: zero-fill after reset, then arbitrated writeback
module regfile_wr_ctrl
  import regfile_pkg::*;
#(
  parameter int RWIDTH = RF_RWIDTH,
  parameter int DWIDTH = RF_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [RWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [RWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_data,
  output logic              req1_ready,
  output logic [RWIDTH-1:0] rf_wa,
  output logic [DWIDTH-1:0] rf_wd,
  output logic              rf_we,
  output logic              init_done
);

  wr_state_t         r_state;
  wr_state_t         w_state_next;
  logic [RWIDTH-1:0] r_clr_cnt;
  logic              w_clr_last;
  logic [1:0]        w_gnt;
  logic              w_run;

  logic [RWIDTH-1:0] r_rf_wa;
  logic [DWIDTH-1:0] r_rf_wd;
  logic              r_rf_we;
  logic [RWIDTH-1:0] w_wa_next;
  logic [DWIDTH-1:0] w_wd_next;
  logic              w_we_next;

  assign w_clr_last = (r_clr_cnt == {RWIDTH{1'b1}});
  assign w_run      = (r_state == ST_RUN);

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1_valid, req0_valid}),
    .en  (w_run),
    .gnt (w_gnt)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign init_done  = w_run;
  assign rf_wa      = r_rf_wa;
  assign rf_wd      = r_rf_wd;
  assign rf_we      = r_rf_we;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // leave the clear phase on the edge that issues the top-address write
  always_comb begin
    w_state_next = r_state;
    if ((r_state == ST_CLEAR) && w_clr_last) begin
      w_state_next = ST_RUN;
    end
  end

  // clear address counter; stops at the top address instead of wrapping to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_cnt <= {{(RWIDTH-1){1'b0}}, 1'b1};
    end else if ((r_state == ST_CLEAR) && !w_clr_last) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // select what the write port carries next: clear data, a granted request, or nothing
  always_comb begin
    w_wa_next = r_rf_wa;
    w_wd_next = r_rf_wd;
    w_we_next = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_wa_next = r_clr_cnt;
        w_wd_next = '0;
        w_we_next = 1'b1;
      end
      ST_RUN: begin
        // address 0 is hardwired zero: the request is consumed but never written
        if (w_gnt[0]) begin
          if (req0_addr != '0) begin
            w_wa_next = req0_addr;
            w_wd_next = req0_data;
            w_we_next = 1'b1;
          end
        end else if (w_gnt[1]) begin
          if (req1_addr != '0) begin
            w_wa_next = req1_addr;
            w_wd_next = req1_data;
            w_we_next = 1'b1;
          end
        end
      end
      default: begin
        w_we_next = 1'b0;
      end
    endcase
  end

  // registered write-port outputs; reset drops any pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_wa <= '0;
      r_rf_wd <= '0;
      r_rf_we <= 1'b0;
    end else begin
      r_rf_wa <= w_wa_next;
      r_rf_wd <= w_wd_next;
      r_rf_we <= w_we_next;
    end
  end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// tb/tb_regfile_wr_ctrl.sv - self-checking bench for regfile_wr_ctrl
module tb_regfile_wr_ctrl;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [5:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [5:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic [5:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        rf_we;
  logic        init_done;

  int n_tests;
  int n_fail;

  regfile_wr_ctrl #(.RWIDTH(6), .DWIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .rf_we      (rf_we),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file image built only from what the DUT drives onto the write port
  logic [31:0] dut_rf [0:63];
  always @(posedge clk) begin
    if (rf_we) dut_rf[rf_wa] <= rf_wd;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: clear step count since reset, tie-break owner, expected port contents
  bit          m_active;
  int          m_step;
  bit          m_done;
  int          m_ptr;
  logic        e_we;
  logic [5:0]  e_wa;
  logic [31:0] e_wd;
  bit          e_hold;

  function automatic int exp_grant();
    if (!m_done) return -1;
    if (req0_valid && !req1_valid) return 0;
    if (req1_valid && !req0_valid) return 1;
    if (req0_valid && req1_valid) return m_ptr;
    return -1;
  endfunction

  initial begin
    m_active = 0; m_step = 0; m_done = 0; m_ptr = 0;
    e_we = 0; e_wa = 0; e_wd = 0; e_hold = 1;
  end

  always @(posedge clk) begin
    int g;
    logic [5:0]  ad;
    logic [31:0] dd;
    if (rst) begin
      m_active = 1; m_step = 0; m_done = 0; m_ptr = 0;
      e_we = 0; e_wa = 0; e_wd = 0; e_hold = 1;
    end else if (m_active) begin
      if (!m_done) begin
        m_step++;
        e_we = 1; e_wa = 6'(m_step); e_wd = 0; e_hold = 1;
        if (m_step == 63) m_done = 1;
      end else begin
        g = exp_grant();
        if (g < 0) begin
          e_we = 0;
        end else begin
          ad = (g == 1) ? req1_addr : req0_addr;
          dd = (g == 1) ? req1_data : req0_data;
          m_ptr = 1 - g;
          if (ad != 0) begin
            e_we = 1; e_wa = ad; e_wd = dd; e_hold = 1;
          end else begin
            e_we = 0; e_hold = 0;
          end
        end
      end
    end
  end

  // compare every cycle, mid-period
  always @(negedge clk) begin
    int g;
    if (m_active) begin
      check("rf_we", {31'd0, rf_we}, {31'd0, e_we});
      if (e_hold) begin
        check("rf_wa", {26'd0, rf_wa}, {26'd0, e_wa});
        check("rf_wd", rf_wd, e_wd);
      end
      check("init_done", {31'd0, init_done}, {31'd0, m_done});
      g = exp_grant();
      if (!m_done) begin
        check("req0_ready_clr", {31'd0, req0_ready}, 32'd0);
        check("req1_ready_clr", {31'd0, req1_ready}, 32'd0);
      end else begin
        if (req0_valid) check("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
        if (req1_valid) check("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  seq_wa [0:4];
  logic [31:0] seq_wd [0:4];

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    seq_wa[0] = 6'd4; seq_wa[1] = 6'd3; seq_wa[2] = 6'd4; seq_wa[3] = 6'd3; seq_wa[4] = 6'd4;
    seq_wd[0] = 32'h22; seq_wd[1] = 32'h11; seq_wd[2] = 32'h22; seq_wd[3] = 32'h11; seq_wd[4] = 32'h22;

    tick();
    tick();
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_wa", {26'd0, rf_wa}, 32'd0);
    check("rst_wd", rf_wd, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    rst = 0;

    // clear sequence: edge k writes zero to address k
    for (int k = 1; k <= 63; k++) begin
      tick();
      check("clr_we", {31'd0, rf_we}, 32'd1);
      check("clr_wa", {26'd0, rf_wa}, k);
      check("clr_wd", rf_wd, 32'd0);
      check("clr_init", {31'd0, init_done}, (k == 63) ? 32'd1 : 32'd0);
    end

    // single requester accepted on edge 64
    req0_valid = 1; req0_addr = 6'd5; req0_data = 32'hDEADBEEF;
    #1;
    check("t1_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    check("t1_wa", {26'd0, rf_wa}, 32'd5);
    check("t1_wd", rf_wd, 32'hDEADBEEF);
    check("t1_we", {31'd0, rf_we}, 32'd1);
    req0_valid = 0;
    tick();
    check("t1_we_off", {31'd0, rf_we}, 32'd0);
    tick();

    // both valid continuously: req0 just won, so req1 goes first and grants alternate
    req0_valid = 1; req0_addr = 6'd3; req0_data = 32'h11;
    req1_valid = 1; req1_addr = 6'd4; req1_data = 32'h22;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_wa", {26'd0, rf_wa}, {26'd0, seq_wa[i]});
      check("t2_wd", rf_wd, seq_wd[i]);
      check("t2_we", {31'd0, rf_we}, 32'd1);
    end
    req0_valid = 0; req1_valid = 0;
    tick();

    // same destination: requester 0 has priority, requester 1's data persists
    req0_valid = 1; req0_addr = 6'd7; req0_data = 32'hAAAA;
    req1_valid = 1; req1_addr = 6'd7; req1_data = 32'hBBBB;
    #1;
    check("t3_ready0", {31'd0, req0_ready}, 32'd1);
    check("t3_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    check("t3_wd_first", rf_wd, 32'hAAAA);
    req0_valid = 0;
    #1;
    check("t3_ready1_b", {31'd0, req1_ready}, 32'd1);
    tick();
    check("t3_wd_second", rf_wd, 32'hBBBB);
    check("t3_wa", {26'd0, rf_wa}, 32'd7);
    req1_valid = 0;
    tick();
    tick();
    check("t3_readback_r7", dut_rf[7], 32'hBBBB);

    // write to register 0 is consumed without a write strobe
    req1_valid = 1; req1_addr = 6'd0; req1_data = 32'hFFFFFFFF;
    #1;
    check("t4_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    check("t4_we", {31'd0, rf_we}, 32'd0);
    req1_valid = 0;
    tick();

    // reset mid-clear restarts from address 1
    rst = 1;
    tick();
    rst = 0;
    for (int k = 1; k <= 30; k++) tick();
    check("t5_wa30", {26'd0, rf_wa}, 32'd30);
    rst = 1;
    tick();
    check("t5_we_rst", {31'd0, rf_we}, 32'd0);
    rst = 0;
    tick();
    check("t5_restart_wa", {26'd0, rf_wa}, 32'd1);
    check("t5_restart_we", {31'd0, rf_we}, 32'd1);
    for (int k = 2; k <= 63; k++) tick();
    check("t5_init", {31'd0, init_done}, 32'd1);

    // reset while a write is pending on the port discards it
    req0_valid = 1; req0_addr = 6'd9; req0_data = 32'h99;
    tick();
    check("t6_we_pending", {31'd0, rf_we}, 32'd1);
    check("t6_wa_pending", {26'd0, rf_wa}, 32'd9);
    req0_valid = 0;
    rst = 1;
    tick();
    check("t6_we_rst", {31'd0, rf_we}, 32'd0);
    check("t6_init_rst", {31'd0, init_done}, 32'd0);
    rst = 0;
    tick();
    check("t6_restart_wa", {26'd0, rf_wa}, 32'd1);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
